// File: rtl/wb_regfile_commit.sv
// ---------------------------------------------------------------------------
// wb_regfile_commit
//
// Writeback/commit stage at the tail of the MEM/WB pipeline register.
// Retires valid instructions into the architectural register file, serves two
// combinational read ports with write-through bypass, redirects fetch on any
// committed write to the PC register (highest index), retires the stop
// instruction into a sticky halt state and keeps retirement statistics.
//
// Slot interface: in_Validity_MEM_WB is a valid-only qualifier with no ready
// back-pressure. The slot is consumed on every rising edge on which it is
// valid and the stage is in RUN; bubbles (valid=0) are ignored whatever the
// other slot fields carry.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset (highest priority)
//   in_Validity_MEM_WB    slot valid
//   in_Result, in_RDest   writeback data / destination register
//   in_W_reg              instruction writes a register
//   in_stop               instruction is the stop/halt instruction
//   in_pc                 PC of the retiring instruction
//   in_BPR                branch-prediction-related flag
//   rd_addr_a/b           read port addresses
//   rd_data_a/b           combinational read data (bypassed)
//   pc_redirect           one-cycle pulse after a committed PC-register write
//   pc_target             value last written to the PC register
//   halted                sticky halt indicator (FSM in HALT)
//   last_pc               PC of the last committed instruction
//   retire_count          committed instructions, wraps
//   bpr_count             committed instructions with in_BPR=1, wraps
// ---------------------------------------------------------------------------
module wb_regfile_commit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_Validity_MEM_WB,
    input  logic [DATA_W-1:0] in_Result,
    input  logic [ADDR_W-1:0] in_RDest,
    input  logic              in_W_reg,
    input  logic              in_stop,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_BPR,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              halted,
    output logic [DATA_W-1:0] last_pc,
    output logic [CNT_W-1:0]  retire_count,
    output logic [CNT_W-1:0]  bpr_count
);

    localparam int                NREGS  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_REG = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic commit;
    logic wr_en;
    logic pc_wr;

    logic [DATA_W-1:0] regs_q [NREGS];

    // -----------------------------------------------------------------------
    // Commit qualification
    // -----------------------------------------------------------------------
    assign commit = (state_q == ST_RUN) && in_Validity_MEM_WB;
    assign wr_en  = commit && in_W_reg;
    assign pc_wr  = wr_en && (in_RDest == PC_REG);

    // -----------------------------------------------------------------------
    // Run/halt FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // HALT is only left through reset, so it has no outgoing transition here.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (commit && in_stop) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign halted = (state_q == ST_HALT);

    // -----------------------------------------------------------------------
    // Register file. R0 is an ordinary register. The stop instruction's own
    // write lands on the same edge that enters HALT because wr_en is derived
    // from the current (RUN) state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[in_RDest] <= in_Result;
        end
    end

    // Write-through bypass: a read of the register being committed this cycle
    // returns the incoming result so decode sees it without a stall.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (wr_en && (rd_addr_a == in_RDest)) begin
            rd_data_a = in_Result;
        end
    end

    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if (wr_en && (rd_addr_b == in_RDest)) begin
            rd_data_b = in_Result;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch redirect on PC-register writes. pc_redirect is re-evaluated every
    // edge, giving a one-cycle pulse per committed PC write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_redirect <= 1'b0;
            pc_target   <= '0;
        end else begin
            pc_redirect <= pc_wr;
            if (pc_wr) begin
                pc_target <= in_Result;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Retirement statistics
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc      <= '0;
            retire_count <= '0;
            bpr_count    <= '0;
        end else if (commit) begin
            last_pc      <= in_pc;
            retire_count <= retire_count + CNT_ONE;
            if (in_BPR) begin
                bpr_count <= bpr_count + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/wb_regfile_commit.md
Name: wb_regfile_commit

Overview:
- Writeback/commit end of the MEM/WB interface: consumes the MEM/WB pipeline register outputs and commits results into the 8x16 architectural register file.
- Provides two combinational read ports with write-through bypass for decode/register-read.
- Detects R7 (PC) writes and issues a fetch redirect.
- Retires the stop instruction into a sticky halt state and keeps retirement/BPR statistics counters.

Parameters:
DATA_W, 16, register/result width
ADDR_W, 3, register address width (2**ADDR_W registers; highest index is the PC register R7)
CNT_W, 16, width of retirement and BPR counters

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_Validity_MEM_WB  input  1  MEM/WB slot holds a valid instruction
in_Result  input  DATA_W  writeback data
in_RDest  input  ADDR_W  destination register
in_W_reg  input  1  instruction writes a register
in_stop  input  1  instruction is the stop/halt instruction
in_pc  input  DATA_W  PC of the retiring instruction
in_BPR  input  1  branch-prediction-related flag carried down the pipe
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  DATA_W  read port A data (combinational)
rd_data_b  output  DATA_W  read port B data (combinational)
pc_redirect  output  1  registered; one-cycle pulse after a committed R7 write
pc_target  output  DATA_W  registered; value written to R7
halted  output  1  registered; sticky halt indicator
last_pc  output  DATA_W  registered; PC of last committed instruction
retire_count  output  CNT_W  registered; committed valid instructions, wraps
bpr_count  output  CNT_W  registered; committed instructions with in_BPR=1, wraps

Behaviour:
- Interface decision: one clock, `clk`; reset is `reset`, synchronous and active-high. Reset has priority over every other event in the same edge.
- Reset values:
  - all 8 registers = 0
  - pc_redirect = 0, pc_target = 0
  - halted = 0, FSM = RUN
  - last_pc = 0, retire_count = 0, bpr_count = 0
- FSM has two states, RUN and HALT.
  - RUN -> HALT on an edge where commit = 1 and in_stop = 1.
  - HALT -> RUN only via reset.
  - halted = 1 in HALT.
- commit = (FSM == RUN) & in_Validity_MEM_WB. Invalid slots (bubbles) have no effect, regardless of the in_W_reg, in_stop and in_BPR values.
- wr_en = commit & in_W_reg. On the edge with wr_en, reg[in_RDest] <= in_Result.
- The stop instruction's own write, if in_W_reg = 1, is committed on the same edge that enters HALT. In HALT, no register write occurs and no counter or last_pc update occurs.
- On commit:
  - retire_count += 1, modulo 2**CNT_W
  - if in_BPR = 1, bpr_count += 1, modulo 2**CNT_W
  - last_pc <= in_pc
- pc_redirect <= wr_en & (in_RDest == 7), every edge; pc_target <= in_Result when that condition holds, otherwise it keeps its value. pc_redirect is therefore a one-cycle pulse, repeated on back-to-back R7 writes.
- Read ports (combinational), same rules for port B:
  - if wr_en & (rd_addr_a == in_RDest), rd_data_a = in_Result (bypass);
  - otherwise rd_data_a = reg[rd_addr_a].
  - Bypass is gated by wr_en, so it never applies in HALT, for invalid slots, or when in_W_reg = 0.
- R0 is an ordinary writable register; it is not hardwired to zero.
- Latency: write is visible through the array one cycle after commit, and combinationally through the bypass in the commit cycle.
- Reset asserted during HALT or in the same cycle as a valid stop: result is the reset state and RUN.

Test Plan:
- After reset, write R3=16'hBEEF (valid, W_reg=1), read A=3 in the same cycle -> rd_data_a=BEEF via bypass. Next cycle -> BEEF from the array; retire_count=1.
- Invalid slot with W_reg=1, RDest=2, Result=1234 -> R2 stays 0, no bypass, retire_count unchanged.
- Valid write R7=16'h0040 -> next cycle pc_redirect=1 and pc_target=0040; following cycle pc_redirect=0.
- 5 valid commits, 2 with BPR=1, then valid stop with W_reg=1, RDest=1, Result=0007:
  - after the stop edge: R1=0007, halted=1, retire_count=6, bpr_count=2, last_pc = stop's pc;
  - further valid writes -> no change to any register or counter.
- Preload retire_count to 16'hFFFF via 65535 commits, then 1 more commit -> retire_count=0 (wrap).
- Reset asserted while halted, with a valid write presented the same cycle -> all registers 0, halted=0, counters 0, no write.
